f0_sbox_stage: RTL and testbench

F0_SBOX_STAGE -- requirements
Module: f0_sbox_stage

---
 rtl/f0_sbox_stage.sv | 163 ++++++++++++++++
 tb/tb_f0_sbox_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/f0_sbox_stage.sv
// f0_sbox_stage: CLEFIA F-function S-box stage. Latches X = data ^ rk and
// substitutes its four bytes as {S0, S1, S0, S1}. The result is held until the
// downstream stage takes it.
// Build option: define F0_PARALLEL_EN for the four-S-box datapath, which
// substitutes all bytes in SUB0. The default build is the serial datapath,
// which uses two S-boxes over SUB0 and SUB1.

// CLEFIA S0: 256-entry lookup
module f0_sbox_s0 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] TAB [256] = '{
    8'h57,8'h49,8'hd1,8'hc6,8'h2f,8'h33,8'h74,8'hfb,8'h95,8'h6d,8'h82,8'hea,8'h0e,8'hb0,8'ha8,8'h1c,
    8'h28,8'hd0,8'h4b,8'h92,8'h5c,8'hee,8'h85,8'hb1,8'hc4,8'h0a,8'h76,8'h3d,8'h63,8'hf9,8'h17,8'haf,
    8'hbf,8'ha1,8'h19,8'h65,8'hf7,8'h7a,8'h32,8'h20,8'h06,8'hce,8'he4,8'h83,8'h9d,8'h5b,8'h4c,8'hd8,
    8'h42,8'h5d,8'h2e,8'he8,8'hd4,8'h9b,8'h0f,8'h13,8'h3c,8'h89,8'h67,8'hc0,8'h71,8'haa,8'hb6,8'hf5,
    8'ha4,8'hbe,8'hfd,8'h8c,8'h12,8'h00,8'h97,8'hda,8'h78,8'he1,8'hcf,8'h6b,8'h39,8'h43,8'h55,8'h26,
    8'h30,8'h98,8'hcc,8'hdd,8'heb,8'h54,8'hb3,8'h8f,8'h4e,8'h16,8'hfa,8'h22,8'ha5,8'h77,8'h09,8'h61,
    8'hd6,8'h2a,8'h53,8'h37,8'h45,8'hc1,8'h6c,8'hae,8'hef,8'h70,8'h08,8'h99,8'h8b,8'h1d,8'hf2,8'hb4,
    8'he9,8'hc7,8'h9f,8'h4a,8'h31,8'h25,8'hfe,8'h7c,8'hd3,8'ha2,8'hbd,8'h56,8'h14,8'h88,8'h60,8'h0b,
    8'hcd,8'he2,8'h34,8'h50,8'h9e,8'hdc,8'h11,8'h05,8'h2b,8'hb7,8'ha9,8'h48,8'hff,8'h66,8'h8a,8'h73,
    8'h03,8'h75,8'h86,8'hf1,8'h6a,8'ha7,8'h40,8'hc2,8'hb9,8'h2c,8'hdb,8'h1f,8'h58,8'h94,8'h3e,8'hed,
    8'hfc,8'h1b,8'ha0,8'h04,8'hb8,8'h8d,8'he6,8'h59,8'h62,8'h93,8'h35,8'h7e,8'hca,8'h21,8'hdf,8'h47,
    8'h15,8'hf3,8'hba,8'h7f,8'ha6,8'h69,8'hc8,8'h4d,8'h87,8'h3b,8'h9c,8'h01,8'he0,8'hde,8'h24,8'h52,
    8'h7b,8'h0c,8'h68,8'h1e,8'h80,8'hb2,8'h5a,8'he7,8'had,8'hd5,8'h23,8'hf4,8'h46,8'h3f,8'h91,8'hc9,
    8'h6e,8'h84,8'h72,8'hbb,8'h0d,8'h18,8'hd9,8'h96,8'hf0,8'h5f,8'h41,8'hac,8'h27,8'hc5,8'he3,8'h3a,
    8'h81,8'h6f,8'h07,8'ha3,8'h79,8'hf6,8'h2d,8'h38,8'h1a,8'h44,8'h5e,8'hb5,8'hd2,8'hec,8'hcb,8'h90,
    8'h9a,8'h36,8'he5,8'h29,8'hc3,8'h4f,8'hab,8'h64,8'h51,8'hf8,8'h10,8'hd7,8'hbc,8'h02,8'h7d,8'h8e
  };
  assign y = TAB[a];
endmodule

// CLEFIA S1: 256-entry lookup
module f0_sbox_s1 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] TAB [256] = '{
    8'h6c,8'hda,8'hc3,8'he9,8'h4e,8'h9d,8'h0a,8'h3d,8'hb8,8'h36,8'hb4,8'h38,8'h13,8'h34,8'h0c,8'hd9,
    8'hbf,8'h74,8'h94,8'h8f,8'hb7,8'h9c,8'he5,8'hdc,8'h9e,8'h07,8'h49,8'h4f,8'h98,8'h2c,8'hb0,8'h93,
    8'h12,8'heb,8'hcd,8'hb3,8'h92,8'he7,8'h41,8'h60,8'he3,8'h21,8'h27,8'h3b,8'he6,8'h19,8'hd2,8'h0e,
    8'h91,8'h11,8'hc7,8'h3f,8'h2a,8'h8e,8'ha1,8'hbc,8'h2b,8'hc8,8'hc5,8'h0f,8'h5b,8'hf3,8'h87,8'h8b,
    8'hfb,8'hf5,8'hde,8'h20,8'hc6,8'ha7,8'h84,8'hce,8'hd8,8'h65,8'h51,8'hc9,8'ha4,8'hef,8'h43,8'h53,
    8'h25,8'h5d,8'h9b,8'h31,8'he8,8'h3e,8'h0d,8'hd7,8'h80,8'hff,8'h69,8'h8a,8'hba,8'h0b,8'h73,8'h5c,
    8'h6e,8'h54,8'h15,8'h62,8'hf6,8'h35,8'h30,8'h52,8'ha3,8'h16,8'hd3,8'h28,8'h32,8'hfa,8'haa,8'h5e,
    8'hcf,8'hea,8'hed,8'h78,8'h33,8'h58,8'h09,8'h7b,8'h63,8'hc0,8'hc1,8'h46,8'h1e,8'hdf,8'ha9,8'h99,
    8'h55,8'h04,8'hc4,8'h86,8'h39,8'h77,8'h82,8'hec,8'h40,8'h18,8'h90,8'h97,8'h59,8'hdd,8'h83,8'h1f,
    8'h9a,8'h37,8'h06,8'h24,8'h64,8'h7c,8'ha5,8'h56,8'h48,8'h08,8'h85,8'hd0,8'h61,8'h26,8'hca,8'h6f,
    8'h7e,8'h6a,8'hb6,8'h71,8'ha0,8'h70,8'h05,8'hd1,8'h45,8'h8c,8'h23,8'h1c,8'hf0,8'hee,8'h89,8'had,
    8'h7a,8'h4b,8'hc2,8'h2f,8'hdb,8'h5a,8'h4d,8'h76,8'h67,8'h17,8'h2d,8'hf4,8'hcb,8'hb1,8'h4a,8'ha8,
    8'hb5,8'h22,8'h47,8'h3a,8'hd5,8'h10,8'h4c,8'h72,8'hcc,8'h00,8'hf9,8'he0,8'hfd,8'he2,8'hfe,8'hae,
    8'hf8,8'h5f,8'hab,8'hf1,8'h1b,8'h42,8'h81,8'hd6,8'hbe,8'h44,8'h29,8'ha6,8'h57,8'hb9,8'haf,8'hf2,
    8'hd4,8'h75,8'h66,8'hbb,8'h68,8'h9f,8'h50,8'h02,8'h01,8'h3c,8'h7f,8'h8d,8'h1a,8'h88,8'hbd,8'hac,
    8'hf7,8'he4,8'h79,8'h96,8'ha2,8'hfc,8'h6d,8'hb2,8'h6b,8'h03,8'he1,8'h2e,8'h7d,8'h14,8'h95,8'h1d
  };
  assign y = TAB[a];
endmodule

module f0_sbox_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_rk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  y0,
  output logic [7:0]  y1,
  output logic [7:0]  y2,
  output logic [7:0]  y3
);
  typedef enum logic [1:0] {IDLE = 2'd0, SUB0 = 2'd1, SUB1 = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

`ifdef F0_PARALLEL_EN
  logic [7:0] sb0_out, sb1_out, sb2_out, sb3_out;

  f0_sbox_s0 u_sb0 (.a(x_q[31:24]), .y(sb0_out));
  f0_sbox_s1 u_sb1 (.a(x_q[23:16]), .y(sb1_out));
  f0_sbox_s0 u_sb2 (.a(x_q[15:8]),  .y(sb2_out));
  f0_sbox_s1 u_sb3 (.a(x_q[7:0]),   .y(sb3_out));
`else
  logic [7:0] s0_in, s1_in, s0_out, s1_out;

  // one S0/S1 pair is shared: high half in SUB0, low half in SUB1
  always_comb begin
    s0_in = x_q[31:24];
    s1_in = x_q[23:16];
    if (state_q == SUB1) begin
      s0_in = x_q[15:8];
      s1_in = x_q[7:0];
    end
  end

  f0_sbox_s0 u_s0 (.a(s0_in), .y(s0_out));
  f0_sbox_s1 u_s1 (.a(s1_in), .y(s1_out));
`endif

  // next state, latched key-mixed word and substituted bytes
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = in_data ^ in_rk;
        state_d = SUB0;
      end
`ifdef F0_PARALLEL_EN
      SUB0: begin
        y_d     = {sb0_out, sb1_out, sb2_out, sb3_out};
        state_d = DONE;
      end
      SUB1: state_d = IDLE;   // not entered in this build; drain safely
`else
      SUB0: begin
        y_d[31:16] = {s0_out, s1_out};
        state_d    = SUB1;
      end
      SUB1: begin
        y_d[15:0] = {s0_out, s1_out};
        state_d   = DONE;
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // handshake outputs are decoded from the next state so they leave a flop
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // state register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= 32'h0;
      y_q         <= 32'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y0 = y_q[31:24];
  assign y1 = y_q[23:16];
  assign y2 = y_q[15:8];
  assign y3 = y_q[7:0];
endmodule

// File: tb/tb_f0_sbox_stage.sv
// Testbench for f0_sbox_stage. The reference builds S0 from its 4-bit
// component S-boxes and GF(2^4) mixing, and uses the S1 table.
module tb_f0_sbox_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_data, in_rk;
  logic        in_ready, out_valid;
  logic [7:0]  y0, y1, y2, y3;

  int checks   = 0;
  int failures = 0;

`ifdef F0_PARALLEL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  localparam int PERIOD = LAT + 1;

  f0_sbox_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rk(in_rk), .out_valid(out_valid),
    .out_ready(out_ready), .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  always #5 clk = ~clk;

  // S0 components
  logic [3:0] SS0 [16] = '{4'he,4'h6,4'hc,4'ha,4'h8,4'h7,4'h2,4'hf,4'hb,4'h1,4'h4,4'h0,4'h5,4'h9,4'hd,4'h3};
  logic [3:0] SS1 [16] = '{4'h6,4'h4,4'h0,4'hd,4'h2,4'hb,4'ha,4'h3,4'h9,4'hc,4'he,4'hf,4'h8,4'h7,4'h5,4'h1};
  logic [3:0] SS2 [16] = '{4'hb,4'h8,4'h5,4'he,4'ha,4'h6,4'h4,4'hc,4'hf,4'h7,4'h2,4'h3,4'h1,4'h0,4'hd,4'h9};
  logic [3:0] SS3 [16] = '{4'ha,4'h2,4'h6,4'hd,4'h3,4'h4,4'h5,4'he,4'h0,4'h7,4'h8,4'h9,4'hb,4'hf,4'hc,4'h1};

  logic [7:0] S1_REF [256] = '{
    8'h6c,8'hda,8'hc3,8'he9,8'h4e,8'h9d,8'h0a,8'h3d,8'hb8,8'h36,8'hb4,8'h38,8'h13,8'h34,8'h0c,8'hd9,
    8'hbf,8'h74,8'h94,8'h8f,8'hb7,8'h9c,8'he5,8'hdc,8'h9e,8'h07,8'h49,8'h4f,8'h98,8'h2c,8'hb0,8'h93,
    8'h12,8'heb,8'hcd,8'hb3,8'h92,8'he7,8'h41,8'h60,8'he3,8'h21,8'h27,8'h3b,8'he6,8'h19,8'hd2,8'h0e,
    8'h91,8'h11,8'hc7,8'h3f,8'h2a,8'h8e,8'ha1,8'hbc,8'h2b,8'hc8,8'hc5,8'h0f,8'h5b,8'hf3,8'h87,8'h8b,
    8'hfb,8'hf5,8'hde,8'h20,8'hc6,8'ha7,8'h84,8'hce,8'hd8,8'h65,8'h51,8'hc9,8'ha4,8'hef,8'h43,8'h53,
    8'h25,8'h5d,8'h9b,8'h31,8'he8,8'h3e,8'h0d,8'hd7,8'h80,8'hff,8'h69,8'h8a,8'hba,8'h0b,8'h73,8'h5c,
    8'h6e,8'h54,8'h15,8'h62,8'hf6,8'h35,8'h30,8'h52,8'ha3,8'h16,8'hd3,8'h28,8'h32,8'hfa,8'haa,8'h5e,
    8'hcf,8'hea,8'hed,8'h78,8'h33,8'h58,8'h09,8'h7b,8'h63,8'hc0,8'hc1,8'h46,8'h1e,8'hdf,8'ha9,8'h99,
    8'h55,8'h04,8'hc4,8'h86,8'h39,8'h77,8'h82,8'hec,8'h40,8'h18,8'h90,8'h97,8'h59,8'hdd,8'h83,8'h1f,
    8'h9a,8'h37,8'h06,8'h24,8'h64,8'h7c,8'ha5,8'h56,8'h48,8'h08,8'h85,8'hd0,8'h61,8'h26,8'hca,8'h6f,
    8'h7e,8'h6a,8'hb6,8'h71,8'ha0,8'h70,8'h05,8'hd1,8'h45,8'h8c,8'h23,8'h1c,8'hf0,8'hee,8'h89,8'had,
    8'h7a,8'h4b,8'hc2,8'h2f,8'hdb,8'h5a,8'h4d,8'h76,8'h67,8'h17,8'h2d,8'hf4,8'hcb,8'hb1,8'h4a,8'ha8,
    8'hb5,8'h22,8'h47,8'h3a,8'hd5,8'h10,8'h4c,8'h72,8'hcc,8'h00,8'hf9,8'he0,8'hfd,8'he2,8'hfe,8'hae,
    8'hf8,8'h5f,8'hab,8'hf1,8'h1b,8'h42,8'h81,8'hd6,8'hbe,8'h44,8'h29,8'ha6,8'h57,8'hb9,8'haf,8'hf2,
    8'hd4,8'h75,8'h66,8'hbb,8'h68,8'h9f,8'h50,8'h02,8'h01,8'h3c,8'h7f,8'h8d,8'h1a,8'h88,8'hbd,8'hac,
    8'hf7,8'he4,8'h79,8'h96,8'ha2,8'hfc,8'h6d,8'hb2,8'h6b,8'h03,8'he1,8'h2e,8'h7d,8'h14,8'h95,8'h1d
  };

  // multiply by 2 in GF(2^4), polynomial x^4 + x + 1
  function automatic logic [3:0] gm2(input logic [3:0] v);
    return v[3] ? ({v[2:0], 1'b0} ^ 4'h3) : {v[2:0], 1'b0};
  endfunction

  function automatic logic [7:0] s0_ref(input logic [7:0] x);
    logic [3:0] t0, t1, u0, u1;
    t0 = SS0[x[7:4]];
    t1 = SS1[x[3:0]];
    u0 = t0 ^ gm2(t1);
    u1 = gm2(t0) ^ t1;
    return {SS2[u0], SS3[u1]};
  endfunction

  function automatic logic [31:0] f0_ref(input logic [31:0] d, input logic [31:0] k);
    logic [31:0] x;
    x = d ^ k;
    return {s0_ref(x[31:24]), S1_REF[x[23:16]], s0_ref(x[15:8]), S1_REF[x[7:0]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one word at a negedge in IDLE; returns edges to out_valid and
  // the output bytes, leaving the bench at the negedge where out_valid is seen.
  task automatic run_word(input logic [31:0] d, input logic [31:0] k,
                          output int lat, output logic [31:0] yv);
    in_data  = d;
    in_rk    = k;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_rk    = $urandom;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    yv = {y0, y1, y2, y3};
  endtask

  logic [31:0] dir_d [3] = '{32'h00000000, 32'hA5A5A5A5, 32'h00000000};
  logic [31:0] dir_k [3] = '{32'h00000000, 32'hA5A5A5A5, 32'hFF00FF00};
  logic [31:0] dir_e [3] = '{32'h576C576C, 32'h576C576C, 32'h8E6C8E6C};

  initial begin
    int          lat;
    logic [31:0] yv, d, k, snap;
    logic [31:0] exp_q [$];
    int          sent, got, cyc, last;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_rk = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_y", {y0, y1, y2, y3}, 32'h0);

    // directed words, including the all-zero and S0(0xFF) cases
    for (int i = 0; i < 3; i++) begin
      run_word(dir_d[i], dir_k[i], lat, yv);
      chk("dir_latency", lat, LAT);
      chk("dir_y_const", yv, dir_e[i]);
      chk("dir_y_model", yv, f0_ref(dir_d[i], dir_k[i]));
      @(negedge clk);
      chk("dir_back_idle", {30'b0, out_valid, in_ready}, 32'd1);
    end

    // random single words
    for (int i = 0; i < 4; i++) begin
      d = $urandom; k = $urandom;
      run_word(d, k, lat, yv);
      chk("rand_latency", lat, LAT);
      chk("rand_y", yv, f0_ref(d, k));
      @(negedge clk);
    end

    // output stall: result held, new words refused
    out_ready = 1'b0;
    d = $urandom; k = $urandom;
    run_word(d, k, lat, yv);
    snap = f0_ref(d, k);
    chk("stall_first_y", yv, snap);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_rk = $urandom;
      @(negedge clk);
      chk("stall_y", {y0, y1, y2, y3}, snap);
      chk("stall_flags", {30'b0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", {30'b0, out_valid, in_ready}, 32'd1);

    // reset while the word is still being substituted
    in_valid = 1'b1; in_data = $urandom; in_rk = $urandom;
    for (int i = 0; i < LAT - 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_flags", {30'b0, out_valid, in_ready}, 32'd1);
    chk("midrst_y", {y0, y1, y2, y3}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_output", {31'b0, out_valid}, 32'd0);
    end

    // streaming: in_valid and out_ready held high, 8 random words
    sent = 0; got = 0; cyc = 0; last = 0;
    in_valid = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else chk("stream_y", {y0, y1, y2, y3}, exp_q.pop_front());
        if (got > 0) chk("stream_gap", cyc - last, PERIOD);
        last = cyc;
        got++;
      end
      if (in_ready && sent < 8) begin
        d = $urandom; k = $urandom;
        in_data = d; in_rk = k; in_valid = 1'b1;
        exp_q.push_back(f0_ref(d, k));
        sent++;
      end else if (sent >= 8) begin
        in_valid = 1'b0;
      end else begin
        in_data = $urandom; in_rk = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_count", got, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
